// File: rtl/dram_axi_master.sv
// Single-outstanding initiator for the simplified AXI-style DRAM channel.
// One core command becomes one AR/R or AW/W/B sequence and ends with a one-cycle result pulse.
module dram_axi_master #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int AXI_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_rw,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    output logic                  busy,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_rdata,
    output logic [1:0]            out_resp,
    output logic                  AR_VALID,
    output logic [AXI_ADDR_W-1:0] AR_ADDR,
    input  logic                  AR_READY,
    input  logic                  R_VALID,
    input  logic [DATA_W-1:0]     R_DATA,
    input  logic [1:0]            R_RESP,
    output logic                  R_READY,
    output logic                  AW_VALID,
    output logic [AXI_ADDR_W-1:0] AW_ADDR,
    input  logic                  AW_READY,
    output logic                  W_VALID,
    output logic [DATA_W-1:0]     W_DATA,
    input  logic                  W_READY,
    input  logic                  B_VALID,
    input  logic [1:0]            B_RESP,
    output logic                  B_READY
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t                  r_state;
    logic [DATA_W-1:0]       r_wdata;
    logic [AXI_ADDR_W-1:0]   w_addr;

    assign w_addr = {{(AXI_ADDR_W-ADDR_W){1'b0}}, in_addr};

    // Every channel output is written only here, so each one is a flop and reset clears it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wdata   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_resp  <= '0;
            AR_VALID  <= 1'b0;
            AR_ADDR   <= '0;
            R_READY   <= 1'b0;
            AW_VALID  <= 1'b0;
            AW_ADDR   <= '0;
            W_VALID   <= 1'b0;
            W_DATA    <= '0;
            B_READY   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_wdata <= in_wdata;
                        busy    <= 1'b1;
                        if (in_rw) begin
                            AW_VALID <= 1'b1;
                            AW_ADDR  <= w_addr;
                            r_state  <= S_AW;
                        end else begin
                            AR_VALID <= 1'b1;
                            AR_ADDR  <= w_addr;
                            r_state  <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (AR_READY) begin
                        AR_VALID <= 1'b0;
                        AR_ADDR  <= '0;
                        R_READY  <= 1'b1;
                        r_state  <= S_R;
                    end
                end
                S_R: begin
                    if (R_VALID) begin
                        R_READY   <= 1'b0;
                        out_valid <= 1'b1;
                        out_rdata <= R_DATA;
                        out_resp  <= R_RESP;
                        r_state   <= S_DONE;
                    end
                end
                S_AW: begin
                    if (AW_READY) begin
                        AW_VALID <= 1'b0;
                        AW_ADDR  <= '0;
                        W_VALID  <= 1'b1;
                        W_DATA   <= r_wdata;
                        r_state  <= S_W;
                    end
                end
                S_W: begin
                    if (W_READY) begin
                        W_VALID <= 1'b0;
                        W_DATA  <= '0;
                        B_READY <= 1'b1;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (B_VALID) begin
                        B_READY   <= 1'b0;
                        out_valid <= 1'b1;
                        out_rdata <= '0;
                        out_resp  <= B_RESP;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    out_valid <= 1'b0;
                    out_rdata <= '0;
                    out_resp  <= '0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
